// File: rtl/flit_mux_2to1.sv
// Two-input NoC flit multiplexer with one-hot select, lowest-index priority,
// zero-gating of idle/invalid paths and an optional single output register stage.
module flit_mux_2to1 #(
    parameter int unsigned DATA_W  = 66,
    parameter int unsigned VCH_W   = 2,
    parameter int unsigned SEL_W   = 5,
    parameter int unsigned OUT_REG = 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [DATA_W-1:0] idata_0,
    input  logic              ivalid_0,
    input  logic [VCH_W-1:0]  ivch_0,
    input  logic [DATA_W-1:0] idata_1,
    input  logic              ivalid_1,
    input  logic [VCH_W-1:0]  ivch_1,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic [VCH_W-1:0]  ovch
);

    logic [DATA_W-1:0] w_next_data;
    logic              w_next_valid;
    logic [VCH_W-1:0]  w_next_vch;

    // Upper select bits address other router ports and never pick an input here.
    logic w_unused_sel_hi;
    assign w_unused_sel_hi = |sel[SEL_W-1:2];

    // Select decode with input 0 priority; an invalid or unselected path drives zeros.
    always_comb begin
        w_next_data  = {DATA_W{1'b0}};
        w_next_valid = 1'b0;
        w_next_vch   = {VCH_W{1'b0}};
        if (sel[0]) begin
            if (ivalid_0) begin
                w_next_data  = idata_0;
                w_next_valid = 1'b1;
                w_next_vch   = ivch_0;
            end else begin
                w_next_valid = 1'b0;
            end
        end else if (sel[1]) begin
            if (ivalid_1) begin
                w_next_data  = idata_1;
                w_next_valid = 1'b1;
                w_next_vch   = ivch_1;
            end else begin
                w_next_valid = 1'b0;
            end
        end else begin
            w_next_valid = 1'b0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [DATA_W-1:0] r_data;
            logic              r_valid;
            logic [VCH_W-1:0]  r_vch;

            // Output pipeline stage; reset drops any in-flight flit immediately.
            always_ff @(posedge clk or posedge rst_) begin
                if (rst_) begin
                    r_data  <= {DATA_W{1'b0}};
                    r_valid <= 1'b0;
                    r_vch   <= {VCH_W{1'b0}};
                end else begin
                    r_data  <= w_next_data;
                    r_valid <= w_next_valid;
                    r_vch   <= w_next_vch;
                end
            end

            assign odata  = r_data;
            assign ovalid = r_valid;
            assign ovch   = r_vch;
        end else begin : g_comb
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst_;

            assign odata  = w_next_data;
            assign ovalid = w_next_valid;
            assign ovch   = w_next_vch;
        end
    endgenerate

endmodule

// File: tb/tb_flit_mux_2to1.sv
// Scoreboard bench: a registered and a combinational build share the same stimulus.
module tb_flit_mux_2to1;

    localparam int DW = 66;
    localparam int VW = 2;
    typedef logic [DW+VW:0] out_t;

    logic          clk = 1'b0;
    logic          rst_ = 1'b1;
    logic [DW-1:0] idata_0 = '0, idata_1 = '0;
    logic          ivalid_0 = 1'b0, ivalid_1 = 1'b0;
    logic [VW-1:0] ivch_0 = '0, ivch_1 = '0;
    logic [4:0]    sel = 5'b00000;

    logic [DW-1:0] odata_r, odata_c;
    logic          ovalid_r, ovalid_c;
    logic [VW-1:0] ovch_r, ovch_c;

    int   total = 0;
    int   bad = 0;
    out_t q[$];
    out_t e;

    always #5 clk = ~clk;

    flit_mux_2to1 #(.DATA_W(DW), .VCH_W(VW), .SEL_W(5), .OUT_REG(1)) u_reg (
        .clk(clk), .rst_(rst_),
        .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
        .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
        .sel(sel), .odata(odata_r), .ovalid(ovalid_r), .ovch(ovch_r)
    );

    flit_mux_2to1 #(.DATA_W(DW), .VCH_W(VW), .SEL_W(5), .OUT_REG(0)) u_comb (
        .clk(clk), .rst_(rst_),
        .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
        .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
        .sel(sel), .odata(odata_c), .ovalid(ovalid_c), .ovch(ovch_c)
    );

    task automatic set_in(input logic [DW-1:0] d0, input logic v0, input logic [VW-1:0] c0,
                          input logic [DW-1:0] d1, input logic v1, input logic [VW-1:0] c1,
                          input logic [4:0] s);
        idata_0 = d0; ivalid_0 = v0; ivch_0 = c0;
        idata_1 = d1; ivalid_1 = v1; ivch_1 = c1;
        sel = s;
        #1;
    endtask

    task automatic tick(input out_t exp);
        q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] f;
        f = {2'b01, 64'h9};
        set_in(f, 1'b1, 2'b01, '0, 1'b0, 2'b00, 5'b00001);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({odata_r, ovalid_r, ovch_r} !== {(DW+VW+1){1'b0}}) begin
                bad++;
                $display("FAIL reset_hold: got=%h want=0", {odata_r, ovalid_r, ovch_r});
            end
        end
        rst_ = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick({f, 1'b1, 2'b01});
            e = q.pop_front();
            total++;
            if ({odata_r, ovalid_r, ovch_r} !== e) begin
                bad++;
                $display("FAIL reset_release: got=%h want=%h", {odata_r, ovalid_r, ovch_r}, e);
            end
        end
        #3 rst_ = 1'b1;
        #1;
        total++;
        if ({odata_r, ovalid_r, ovch_r} !== {(DW+VW+1){1'b0}}) begin
            bad++;
            $display("FAIL reset_async: got=%h want=0", {odata_r, ovalid_r, ovch_r});
        end
        @(posedge clk);
        #1;
        total++;
        if ({odata_r, ovalid_r, ovch_r} !== {(DW+VW+1){1'b0}}) begin
            bad++;
            $display("FAIL reset_held_mid: got=%h want=0", {odata_r, ovalid_r, ovch_r});
        end
        rst_ = 1'b0;
    endtask

    task automatic test_input1_packet();
        logic [DW-1:0] d0, f;
        d0 = {2'b01, 64'hDEAD_BEEF_0000_0000};
        for (int i = 0; i < 22; i++) begin
            if (i == 0)       f = {2'b01, 32'h0, 32'h4};
            else if (i == 21) f = {2'b11, 64'h0000_0000_CAFE_0001};
            else              f = {2'b10, 32'(i), (i[0] ? 32'h00000FFF : 32'hFFFFFFC0)};
            set_in(d0, 1'b1, 2'b01, f, 1'b1, 2'b10, 5'b00010);
            total++;
            if ({odata_c, ovalid_c, ovch_c} !== {f, 1'b1, 2'b10}) begin
                bad++;
                $display("FAIL pkt_comb[%0d]: got=%h want=%h", i, {odata_c, ovalid_c, ovch_c}, {f, 1'b1, 2'b10});
            end
            tick({f, 1'b1, 2'b10});
            e = q.pop_front();
            total++;
            if ({odata_r, ovalid_r, ovch_r} !== e) begin
                bad++;
                $display("FAIL pkt_reg[%0d]: got=%h want=%h", i, {odata_r, ovalid_r, ovch_r}, e);
            end
        end
    endtask

    task automatic test_gating();
        set_in({2'b10, 64'h1234}, 1'b1, 2'b01, 66'h3_FFFF_FFFF_FFFF_FFFF, 1'b0, 2'b11, 5'b00010);
        total++;
        if ({odata_c, ovalid_c, ovch_c} !== {(DW+VW+1){1'b0}}) begin
            bad++;
            $display("FAIL gate_comb: got=%h want=0", {odata_c, ovalid_c, ovch_c});
        end
        tick({(DW+VW+1){1'b0}});
        e = q.pop_front();
        total++;
        if ({odata_r, ovalid_r, ovch_r} !== e) begin
            bad++;
            $display("FAIL gate_reg: got=%h want=%h", {odata_r, ovalid_r, ovch_r}, e);
        end
    endtask

    task automatic test_priority_none();
        logic [DW-1:0] a, b;
        logic [4:0]    sv [4];
        out_t          ev [4];
        a = {2'b10, 64'hAAAA_5555_0000_1111};
        b = {2'b10, 64'h5555_AAAA_2222_3333};
        sv[0] = 5'b00011; ev[0] = {a, 1'b1, 2'b01};
        sv[1] = 5'b00000; ev[1] = '0;
        sv[2] = 5'b10000; ev[2] = '0;
        sv[3] = 5'b10001; ev[3] = {a, 1'b1, 2'b01};
        for (int i = 0; i < 4; i++) begin
            set_in(a, 1'b1, 2'b01, b, 1'b1, 2'b10, sv[i]);
            total++;
            if ({odata_c, ovalid_c, ovch_c} !== ev[i]) begin
                bad++;
                $display("FAIL prio_comb[%0d]: got=%h want=%h", i, {odata_c, ovalid_c, ovch_c}, ev[i]);
            end
            tick(ev[i]);
            e = q.pop_front();
            total++;
            if ({odata_r, ovalid_r, ovch_r} !== e) begin
                bad++;
                $display("FAIL prio_reg[%0d]: got=%h want=%h", i, {odata_r, ovalid_r, ovch_r}, e);
            end
        end
    endtask

    task automatic test_mid_switch();
        logic [DW-1:0] a, b;
        logic [4:0]    s;
        out_t          x;
        for (int i = 0; i < 8; i++) begin
            a = {2'b10, 32'hA000_0000, 32'(i)};
            b = {2'b10, 32'hB000_0000, 32'(i)};
            s = (i < 4) ? 5'b00001 : 5'b00010;
            x = (i < 4) ? {a, 1'b1, 2'b01} : {b, 1'b1, 2'b11};
            set_in(a, 1'b1, 2'b01, b, 1'b1, 2'b11, s);
            tick(x);
            e = q.pop_front();
            total++;
            if ({odata_r, ovalid_r, ovch_r} !== e) begin
                bad++;
                $display("FAIL switch_reg[%0d]: got=%h want=%h", i, {odata_r, ovalid_r, ovch_r}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_input1_packet();
        test_gating();
        test_priority_none();
        test_mid_switch();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flit_mux_2to1.md
Name: flit_mux_2to1

Overview:
- Two-input flit multiplexer for the NoC router datapath; forwards one of two input flit channels (data, valid, virtual channel) to a single output port under a one-hot select.
- Sits between the crossbar arbitration logic (source of sel) and an output port.
- Output is registered (one pipeline stage) and zero-gated when idle, to keep output toggling minimal for energy characterization.

Parameters:
- DATA_W, 66, flit width: bits [DATA_W-1:DATA_W-2] = flit type (NONE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11), lower 64 bits = payload.
- VCH_W, 2, virtual-channel id width.
- SEL_W, 5, select-vector width (router port count); only bits [1:0] are meaningful here.
- OUT_REG, 1, 1 = registered outputs; 0 = purely combinational path (clk/rst_ unused).

Ports:
- clk  input  1  system clock, rising edge.
- rst_  input  1  asynchronous reset, active-HIGH despite the trailing underscore.
- idata_0  input  DATA_W  flit on input 0.
- ivalid_0  input  1  input 0 flit valid.
- ivch_0  input  VCH_W  input 0 virtual channel.
- idata_1  input  DATA_W  flit on input 1.
- ivalid_1  input  1  input 1 flit valid.
- ivch_1  input  VCH_W  input 1 virtual channel.
- sel  input  SEL_W  one-hot select; bit i selects input i.
- odata  output  DATA_W  selected flit.
- ovalid  output  1  selected valid.
- ovch  output  VCH_W  selected virtual channel.

Behaviour:
- Select decode:
  - sel[0]=1 -> input 0.
  - else sel[1]=1 -> input 1.
  - Both set -> input 0 wins (lowest index priority).
  - sel[1:0]=0 (including sel bits [SEL_W-1:2] set alone) -> no selection.
- Selected path, valid=1: next_odata = idata_k, next_ovalid = 1, next_ovch = ivch_k.
- Selected path, valid=0: next_odata = 0, next_ovalid = 0, next_ovch = 0 (zero-gating; data is not passed while invalid).
- No selection: next_odata = 0, next_ovalid = 0, next_ovch = 0.
- OUT_REG=1: outputs load next_* on every rising clk edge. Latency is exactly 1 cycle from input/sel change to output. No stall or backpressure; a new flit is accepted every cycle.
- OUT_REG=0: outputs equal next_* combinationally, with zero latency.
- Reset (OUT_REG=1): rst_=1 asynchronously forces odata=0, ovalid=0, ovch=0 and holds them while asserted. Inputs are ignored during reset. The first capture happens on the first rising edge after rst_ deasserts.
- Reset asserted mid-packet: outputs clear immediately and the in-flight flit is dropped. The block keeps no packet state; head/data/tail types pass through unmodified and the block never inspects them.
- sel may change on any cycle, including mid-packet. The output follows the new selection on the next edge; no packet-boundary locking.
- No arithmetic; all widths pass straight through, no truncation.

Test Plan:
- Reset: hold rst_=1, drive idata_0={2'b01,64'h9}, ivalid_0=1, sel=5'b00001 -> odata=0, ovalid=0, ovch=0 while reset is asserted and immediately on assertion mid-cycle.
- Input-1 packet: sel=5'b00010; drive a HEAD flit {2'b01,32'h0,32'h4}, 20 DATA flits of pattern words (32'hFFFFFFC0, 32'h00000FFF, ...), then a TAIL flit; ivalid_1=1 throughout -> each flit appears on odata exactly one cycle later with ovalid=1, ovch=ivch_1; input 0 traffic never appears.
- Gating: sel=5'b00010, ivalid_1=0, idata_1=66'h3_FFFF_FFFF_FFFF_FFFF -> odata=0, ovalid=0 next cycle.
- Priority and none-selected:
  - sel=5'b00011 with both inputs valid -> output shows input 0.
  - sel=5'b00000 or 5'b10000 -> odata=0, ovalid=0.
- Mid-packet switch: change sel 5'b00001 -> 5'b00010 during a burst -> output switches source on the following edge with no idle cycle and no flit repeated.
- OUT_REG=0 build: same stimulus as the input-1 packet -> outputs match the selected input in the same cycle.
